pc_gen_ras: RTL and testbench

// - Fetch-stage PC generator, successor to the basic PC register: configurable reset vector, RVC (2/4-byte) increment, stall.
// - Prioritised redirects (trap > branch > predicted return) and a parametrised return-address stack (RAS).
// - Drives the instruction-fetch address; fed by decode (call/ret/compressed), execute (branch) and trap unit.

---
 rtl/pc_gen_ras_if.sv | 35 +++
 rtl/pc_gen_ras.sv | 117 +++++++++++
 tb/tb_pc_gen_ras.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_ras_if.sv
// Fetch-control bundle between decode/execute/trap sources and the PC generator.
// The master drives redirect and RAS controls; the slave returns the fetch PC and RAS status.
interface pc_gen_ras_if #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic                stall_i;
  logic                trap_i;
  logic [PC_WIDTH-1:0] trap_vector_i;
  logic                branch_i;
  logic [PC_WIDTH-1:0] branch_target_i;
  logic                call_i;
  logic                ret_i;
  logic                compressed_i;
  logic [PC_WIDTH-1:0] pc_o;
  logic [PC_WIDTH-1:0] pc_next_o;
  logic                misaligned_o;
  logic [CntW-1:0]     ras_count_o;
  logic                ras_overflow_o;
  logic                ras_underflow_o;

  modport master (
    output stall_i, trap_i, trap_vector_i, branch_i, branch_target_i, call_i, ret_i,
           compressed_i,
    input  pc_o, pc_next_o, misaligned_o, ras_count_o, ras_overflow_o, ras_underflow_o
  );

  modport slave (
    input  stall_i, trap_i, trap_vector_i, branch_i, branch_target_i, call_i, ret_i,
           compressed_i,
    output pc_o, pc_next_o, misaligned_o, ras_count_o, ras_overflow_o, ras_underflow_o
  );
endinterface

// File: rtl/pc_gen_ras.sv
// Fetch-stage PC generator with prioritised redirects (trap > branch > RAS return)
// and a circular return-address stack that overwrites its oldest entry when full.
module pc_gen_ras #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         RAS_DEPTH    = 4,
  parameter bit                  C_EXT        = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pc_gen_ras_if.slave  bus
);

  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  typedef logic [CntW-1:0]     cnt_t;
  typedef logic [PtrW-1:0]     ptr_t;
  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam cnt_t Full    = cnt_t'(RAS_DEPTH);
  localparam ptr_t LastIdx = ptr_t'(RAS_DEPTH - 1);

  pc_t  pc_q, pc_d;
  cnt_t cnt_q, cnt_d;
  ptr_t ptr_q, ptr_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  pc_t  ras_q [RAS_DEPTH];

  pc_t  inc, seq, ras_top;
  ptr_t top_idx, ptr_inc, wr_idx;
  logic ras_empty, ras_full, ras_hit;
  logic misaligned, update, ras_en, pop, push;

  assign inc       = (C_EXT && bus.compressed_i) ? pc_t'(2) : pc_t'(4);
  assign seq       = pc_q + inc;
  // ptr_q is the next free slot; the top entry sits one below it, circularly.
  assign top_idx   = (ptr_q == '0) ? LastIdx : ptr_q - ptr_t'(1);
  assign ptr_inc   = (ptr_q == LastIdx) ? '0 : ptr_q + ptr_t'(1);
  assign ras_top   = ras_q[top_idx];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == Full);
  assign ras_hit   = bus.ret_i && !ras_empty;

  assign misaligned = bus.branch_i && !bus.trap_i &&
                      (bus.branch_target_i[0] || (!C_EXT && bus.branch_target_i[1]));

  always_comb begin
    pc_d = seq;
    if (bus.trap_i) begin
      pc_d = {bus.trap_vector_i[PC_WIDTH-1:2], 2'b00};
    end else if (bus.branch_i) begin
      pc_d = bus.branch_target_i;
    end else if (ras_hit) begin
      pc_d = ras_top;
    end
  end

  // Trap forces the update even when stalled, but never touches the RAS.
  assign update = bus.trap_i || (!bus.stall_i && !misaligned);
  assign ras_en = update && !bus.trap_i;
  assign pop    = ras_en && ras_hit;
  assign push   = ras_en && bus.call_i;
  // Pop-then-push rewrites the current top in place.
  assign wr_idx = pop ? top_idx : ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (pop && !push) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - cnt_t'(1);
    end else if (push && !pop) begin
      ptr_d = ptr_inc;
      if (!ras_full) begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  assign ovf_d = push && !pop && ras_full;
  assign unf_d = ras_en && bus.ret_i && ras_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (update) begin
        pc_q <= pc_d;
      end
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entries are not reset; only entries below the count are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ras_q[wr_idx] <= seq;
    end
  end

  assign bus.pc_o            = pc_q;
  assign bus.pc_next_o       = pc_d;
  assign bus.misaligned_o    = misaligned;
  assign bus.ras_count_o     = cnt_q;
  assign bus.ras_overflow_o  = ovf_q;
  assign bus.ras_underflow_o = unf_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: instance A (C_EXT=1, reset vector 0x8000_0000) and instance B
// (C_EXT=0, reset vector 0) driven from hand-computed vector tables.
module tb_pc_gen_ras;
  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst_a, rst_b;

  pc_gen_ras_if #(.PC_WIDTH(W), .RAS_DEPTH(D)) bus_a ();
  pc_gen_ras_if #(.PC_WIDTH(W), .RAS_DEPTH(D)) bus_b ();

  pc_gen_ras #(.PC_WIDTH(W), .RESET_VECTOR(32'h8000_0000), .RAS_DEPTH(D), .C_EXT(1'b1)) dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (bus_a.slave)
  );

  pc_gen_ras #(.PC_WIDTH(W), .RESET_VECTOR(32'h0000_0000), .RAS_DEPTH(D), .C_EXT(1'b0)) dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  // ctl = {stall, trap, branch, call, ret, compressed}
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] tv;
    logic [31:0] bt;
    logic [31:0] nx;
    logic        mis;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t ta[$];
  vec_t tbv[$];
  vec_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;

  function automatic vec_t mk(logic [5:0] ctl, logic [31:0] tv, logic [31:0] bt,
                              logic [31:0] nx, logic mis, logic [31:0] pc,
                              logic [31:0] cnt, logic ovf, logic unf);
    vec_t v;
    v.ctl = ctl; v.tv = tv; v.bt = bt; v.nx = nx; v.mis = mis;
    v.pc = pc; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int sel, logic [5:0] ctl, logic [31:0] tv, logic [31:0] bt);
    if (sel == 0) begin
      {bus_a.stall_i, bus_a.trap_i, bus_a.branch_i, bus_a.call_i, bus_a.ret_i,
       bus_a.compressed_i} = ctl;
      bus_a.trap_vector_i = tv;
      bus_a.branch_target_i = bt;
    end else begin
      {bus_b.stall_i, bus_b.trap_i, bus_b.branch_i, bus_b.call_i, bus_b.ret_i,
       bus_b.compressed_i} = ctl;
      bus_b.trap_vector_i = tv;
      bus_b.branch_target_i = bt;
    end
  endtask

  task automatic sample(int sel, output logic [31:0] nx, output logic mis,
                        output logic [31:0] pc, output logic [31:0] cnt,
                        output logic ovf, output logic unf);
    if (sel == 0) begin
      nx = bus_a.pc_next_o; mis = bus_a.misaligned_o; pc = bus_a.pc_o;
      cnt = 32'(bus_a.ras_count_o); ovf = bus_a.ras_overflow_o; unf = bus_a.ras_underflow_o;
    end else begin
      nx = bus_b.pc_next_o; mis = bus_b.misaligned_o; pc = bus_b.pc_o;
      cnt = 32'(bus_b.ras_count_o); ovf = bus_b.ras_overflow_o; unf = bus_b.ras_underflow_o;
    end
  endtask

  // Called at posedge+1: drive, check combinational outputs, then registered state after the edge.
  task automatic run_vec(int sel, int idx, vec_t v);
    vec_t        e;
    logic [31:0] nx, pc, cnt;
    logic        mis, ovf, unf;
    string       tag;
    tag = $sformatf("%s%0d", (sel == 0) ? "a" : "b", idx);
    drive(sel, v.ctl, v.tv, v.bt);
    sb.push_back(v);
    #2;
    sample(sel, nx, mis, pc, cnt, ovf, unf);
    chk({tag, " pc_next"}, nx, v.nx);
    chk({tag, " misaligned"}, 32'(mis), 32'(v.mis));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    sample(sel, nx, mis, pc, cnt, ovf, unf);
    chk({tag, " pc"}, pc, e.pc);
    chk({tag, " count"}, cnt, e.cnt);
    chk({tag, " overflow"}, 32'(ovf), 32'(e.ovf));
    chk({tag, " underflow"}, 32'(unf), 32'(e.unf));
  endtask

  task automatic chk_reset(int sel, string name, logic [31:0] rv);
    logic [31:0] nx, pc, cnt;
    logic        mis, ovf, unf;
    sample(sel, nx, mis, pc, cnt, ovf, unf);
    chk({name, " pc"}, pc, rv);
    chk({name, " count"}, cnt, 32'd0);
    chk({name, " overflow"}, 32'(ovf), 32'd0);
    chk({name, " underflow"}, 32'(unf), 32'd0);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 6'b0, 32'h0, 32'h0);
    drive(1, 6'b0, 32'h0, 32'h0);

    // Instance A: ctl tv bt | pc_next mis pc count ovf unf
    ta.push_back(mk(6'b000100, 0, 0, 32'h8000_0004, 0, 32'h8000_0004, 1, 0, 0));
    ta.push_back(mk(6'b000000, 0, 0, 32'h8000_0008, 0, 32'h8000_0008, 1, 0, 0));
    ta.push_back(mk(6'b000000, 0, 0, 32'h8000_000C, 0, 32'h8000_000C, 1, 0, 0));
    ta.push_back(mk(6'b001000, 0, 32'h100, 32'h100, 0, 32'h100, 0, 0, 0));
    ta.push_back(mk(6'b000001, 0, 0, 32'h102, 0, 32'h102, 0, 0, 0));
    ta.push_back(mk(6'b000000, 0, 0, 32'h106, 0, 32'h106, 0, 0, 0));
    ta.push_back(mk(6'b100000, 0, 0, 32'h10A, 0, 32'h106, 0, 0, 0));
    ta.push_back(mk(6'b100000, 0, 0, 32'h10A, 0, 32'h106, 0, 0, 0));
    ta.push_back(mk(6'b100000, 0, 0, 32'h10A, 0, 32'h106, 0, 0, 0));
    ta.push_back(mk(6'b001000, 0, 32'h200, 32'h200, 0, 32'h200, 0, 0, 0));
    ta.push_back(mk(6'b001100, 0, 32'h400, 32'h400, 0, 32'h400, 1, 0, 0));
    ta.push_back(mk(6'b001000, 0, 32'h410, 32'h410, 0, 32'h410, 1, 0, 0));
    ta.push_back(mk(6'b000010, 0, 0, 32'h204, 0, 32'h204, 0, 0, 0));
    ta.push_back(mk(6'b000010, 0, 0, 32'h208, 0, 32'h208, 0, 0, 1));
    ta.push_back(mk(6'b000000, 0, 0, 32'h20C, 0, 32'h20C, 0, 0, 0));
    ta.push_back(mk(6'b000100, 0, 0, 32'h210, 0, 32'h210, 1, 0, 0));
    ta.push_back(mk(6'b000100, 0, 0, 32'h214, 0, 32'h214, 2, 0, 0));
    ta.push_back(mk(6'b000100, 0, 0, 32'h218, 0, 32'h218, 3, 0, 0));
    ta.push_back(mk(6'b000100, 0, 0, 32'h21C, 0, 32'h21C, 4, 0, 0));
    ta.push_back(mk(6'b000100, 0, 0, 32'h220, 0, 32'h220, 4, 1, 0));
    ta.push_back(mk(6'b000010, 0, 0, 32'h220, 0, 32'h220, 3, 0, 0));
    ta.push_back(mk(6'b000010, 0, 0, 32'h21C, 0, 32'h21C, 2, 0, 0));
    ta.push_back(mk(6'b000010, 0, 0, 32'h218, 0, 32'h218, 1, 0, 0));
    ta.push_back(mk(6'b000010, 0, 0, 32'h214, 0, 32'h214, 0, 0, 0));
    ta.push_back(mk(6'b000010, 0, 0, 32'h218, 0, 32'h218, 0, 0, 1));
    ta.push_back(mk(6'b000100, 0, 0, 32'h21C, 0, 32'h21C, 1, 0, 0));
    ta.push_back(mk(6'b100010, 0, 0, 32'h21C, 0, 32'h21C, 1, 0, 0));
    ta.push_back(mk(6'b111110, 32'h1003, 32'h500, 32'h1000, 0, 32'h1000, 1, 0, 0));
    ta.push_back(mk(6'b000010, 0, 0, 32'h21C, 0, 32'h21C, 0, 0, 0));
    ta.push_back(mk(6'b001100, 0, 32'h301, 32'h301, 1, 32'h21C, 0, 0, 0));
    ta.push_back(mk(6'b001000, 0, 32'h302, 32'h302, 0, 32'h302, 0, 0, 0));
    ta.push_back(mk(6'b000100, 0, 0, 32'h306, 0, 32'h306, 1, 0, 0));
    ta.push_back(mk(6'b000110, 0, 0, 32'h306, 0, 32'h306, 1, 0, 0));
    ta.push_back(mk(6'b000010, 0, 0, 32'h30A, 0, 32'h30A, 0, 0, 0));
    ta.push_back(mk(6'b000100, 0, 0, 32'h30E, 0, 32'h30E, 1, 0, 0));
    ta.push_back(mk(6'b001010, 0, 32'h600, 32'h600, 0, 32'h600, 0, 0, 0));
    ta.push_back(mk(6'b001000, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0, 0));
    ta.push_back(mk(6'b000000, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0));
    ta.push_back(mk(6'b011000, 32'h2001, 32'h3, 32'h2000, 0, 32'h2000, 0, 0, 0));

    // Instance B (no compressed support)
    tbv.push_back(mk(6'b000001, 0, 0, 32'h4, 0, 32'h4, 0, 0, 0));
    tbv.push_back(mk(6'b001000, 0, 32'h302, 32'h302, 1, 32'h4, 0, 0, 0));
    tbv.push_back(mk(6'b001000, 0, 32'h301, 32'h301, 1, 32'h4, 0, 0, 0));
    tbv.push_back(mk(6'b001000, 0, 32'h300, 32'h300, 0, 32'h300, 0, 0, 0));
    tbv.push_back(mk(6'b110000, 32'h1002, 0, 32'h1000, 0, 32'h1000, 0, 0, 0));
    tbv.push_back(mk(6'b001000, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0, 0));
    tbv.push_back(mk(6'b000001, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    chk_reset(0, "reset_a", 32'h8000_0000);

    for (int i = 0; i < 3; i++) run_vec(0, i, ta[i]);

    // Asynchronous reset between edges with a non-empty RAS
    drive(0, 6'b0, 32'h0, 32'h0);
    #2;
    rst_a = 1'b1;
    #1;
    chk_reset(0, "async_reset_a", 32'h8000_0000);
    @(posedge clk);
    #1;
    rst_a = 1'b0;

    for (int i = 3; i < ta.size(); i++) run_vec(0, i, ta[i]);

    rst_b = 1'b0;
    chk_reset(1, "reset_b", 32'h0);
    for (int i = 0; i < tbv.size(); i++) run_vec(1, i, tbv[i]);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
